// File: rtl/midi_pkg.sv
// Shared MIDI constants, scale offsets, FSM state type and key clamp helper
// for the note encoder.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;

  // Major-scale semitone offset of each note index from the base key
  localparam logic [4:0] OFFSET [10] = '{5'd0, 5'd2, 5'd4, 5'd5, 5'd7,
                                         5'd9, 5'd11, 5'd12, 5'd14, 5'd16};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATUS = 2'd1,
    ST_KEY    = 2'd2,
    ST_VEL    = 2'd3
  } state_e;

  typedef logic [6:0] key_t;

  function automatic key_t clamp_key(input logic signed [8:0] sum);
    key_t k;
    if (sum < 9'sd0) begin
      k = 7'd0;
    end else if (sum > 9'sd127) begin
      k = 7'd127;
    end else begin
      k = sum[6:0];
    end
    return k;
  endfunction

endpackage

// File: rtl/midi_note_encoder_if.sv
// Byte-stream valid/ready link from the note encoder to the MIDI UART.
interface midi_note_encoder_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/prio_enc10.sv
// Lowest-set-bit encoder for a 10-bit vector.
module prio_enc10 (
  input  logic [9:0] vec_i,
  output logic [3:0] idx_o,
  output logic       found_o
);

  // Scan from the top so the lowest set bit wins
  always_comb begin
    idx_o   = 4'd0;
    found_o = |vec_i;
    for (int i = 9; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = 4'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/midi_note_encoder.sv
// Turns key-vector changes into 3-byte MIDI Note On/Off messages, one key per
// message, tracking which keys have been announced downstream.
module midi_note_encoder
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL  = 0,
  parameter int unsigned BASE_KEY = 60,
  parameter int unsigned VELOCITY = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 note,
  input  logic [4:0]                 pitchshift,
  input  logic                       ena,
  output logic                       busy,
  midi_note_encoder_if.master        tx
);

  localparam logic [7:0] CH_BYTE  = 8'(CHANNEL);
  localparam logic [7:0] VEL_BYTE = 8'(VELOCITY);

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [9:0]  sent_q, sent_d;
  logic        cur_on_q, cur_on_d;
  key_t        cur_key_q, cur_key_d;
  key_t        keynum_q [10];

  logic [9:0]        target_s, diff_s, sel_mask_s;
  logic [3:0]        sel_idx_s;
  logic              sel_found_s, xfer_s, keynum_we_s;
  logic signed [8:0] sum_s;
  key_t              new_key_s;

  assign target_s   = note & {10{ena}};
  assign diff_s     = target_s ^ sent_q;
  assign sel_mask_s = 10'b1 << sel_idx_s;
  assign xfer_s     = valid_q & tx.byte_ready;

  prio_enc10 u_prio (
    .vec_i   (diff_s),
    .idx_o   (sel_idx_s),
    .found_o (sel_found_s)
  );

  // Key for a Note On: base + scale offset + signed shift, clamped to 0..127
  always_comb begin
    sum_s     = $signed(9'(BASE_KEY) + {4'd0, OFFSET[sel_idx_s]}
                        + {{4{pitchshift[4]}}, pitchshift});
    new_key_s = clamp_key(sum_s);
  end

  // Next-state and output byte sequencing
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sent_d      = sent_q;
    cur_on_d    = cur_on_q;
    cur_key_d   = cur_key_q;
    keynum_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_d = ST_STATUS;
          valid_d = 1'b1;
          if (target_s[sel_idx_s]) begin
            data_d      = MIDI_NOTE_ON | CH_BYTE;
            cur_on_d    = 1'b1;
            cur_key_d   = new_key_s;
            keynum_we_s = 1'b1;
            sent_d      = sent_q | sel_mask_s;
          end else begin
            data_d    = MIDI_NOTE_OFF | CH_BYTE;
            cur_on_d  = 1'b0;
            cur_key_d = keynum_q[sel_idx_s];
            sent_d    = sent_q & ~sel_mask_s;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_STATUS: begin
        if (xfer_s) begin
          state_d = ST_KEY;
          data_d  = {1'b0, cur_key_q};
        end else begin
          state_d = ST_STATUS;
        end
      end
      ST_KEY: begin
        if (xfer_s) begin
          state_d = ST_VEL;
          data_d  = cur_on_q ? VEL_BYTE : 8'h00;
        end else begin
          state_d = ST_KEY;
        end
      end
      ST_VEL: begin
        if (xfer_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          data_d  = 8'h00;
        end else begin
          state_d = ST_VEL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = 8'h00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any message in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 10'd0;
      cur_on_q  <= 1'b0;
      cur_key_q <= 7'd0;
      for (int i = 0; i < 10; i++) begin
        keynum_q[i] <= 7'd0;
      end
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      cur_on_q  <= cur_on_d;
      cur_key_q <= cur_key_d;
      if (keynum_we_s) begin
        keynum_q[sel_idx_s] <= new_key_s;
      end
    end
  end

  assign tx.byte_data  = data_q;
  assign tx.byte_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_midi_note_encoder.sv
// Scoreboard bench for midi_note_encoder: expected bytes are queued when keys
// change and popped as the encoder hands bytes downstream.
module tb_midi_note_encoder;

  localparam int OFFS [10] = '{0, 2, 4, 5, 7, 9, 11, 12, 14, 16};

  logic       clk;
  logic       rst;
  logic [9:0] note, note_hi, note_lo;
  logic [4:0] pitchshift, shift_hi, shift_lo;
  logic       ena;
  logic       busy, busy_hi, busy_lo;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  midi_note_encoder_if dut_if ();
  midi_note_encoder_if hi_if ();
  midi_note_encoder_if lo_if ();

  assign hi_if.byte_ready = 1'b1;
  assign lo_if.byte_ready = 1'b1;

  midi_note_encoder u_dut (
    .clk(clk), .rst(rst), .note(note), .pitchshift(pitchshift), .ena(ena),
    .busy(busy), .tx(dut_if)
  );

  midi_note_encoder #(.BASE_KEY(120)) u_hi (
    .clk(clk), .rst(rst), .note(note_hi), .pitchshift(shift_hi), .ena(1'b1),
    .busy(busy_hi), .tx(hi_if)
  );

  midi_note_encoder #(.BASE_KEY(0)) u_lo (
    .clk(clk), .rst(rst), .note(note_lo), .pitchshift(shift_lo), .ena(1'b1),
    .busy(busy_lo), .tx(lo_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted byte must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && dut_if.byte_valid && dut_if.byte_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got 0x%02h, required no byte", dut_if.byte_data);
      end else begin
        exp_b = sb.pop_front();
        if (dut_if.byte_data !== exp_b) begin
          bad++;
          $display("FAIL byte_stream: got 0x%02h, required 0x%02h", dut_if.byte_data, exp_b);
        end
      end
    end
  end

  function automatic int exp_key(int base, int idx, int shift);
    int s;
    s = base + OFFS[idx] + shift;
    if (s < 0) s = 0;
    if (s > 127) s = 127;
    return s;
  endfunction

  task automatic push_msg(input bit on, input int key);
    logic [7:0] k;
    k = 8'(key);
    sb.push_back(on ? 8'h90 : 8'h80);
    sb.push_back(k);
    sb.push_back(on ? 8'h64 : 8'h00);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !dut_if.byte_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    note = 10'd0; pitchshift = 5'd0; ena = 1'b1; dut_if.byte_ready = 1'b1;
    note_hi = 10'd0; note_lo = 10'd0; shift_hi = 5'd0; shift_lo = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (dut_if.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", dut_if.byte_valid); end
    total++;
    if (dut_if.byte_data !== 8'h00) begin bad++; $display("FAIL reset_data: got 0x%02h, required 0x00", dut_if.byte_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_press();
    int busy_cnt;
    bit ok;
    push_msg(1'b1, 8'h3C);
    note = 10'h001;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (c == 0) begin
        total++;
        if (dut_if.byte_valid !== 1'b0) begin bad++; $display("FAIL press_latency: got valid %b, required 0", dut_if.byte_valid); end
      end
      if (c == 1) begin
        total++;
        if (dut_if.byte_valid !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL press_first_byte: got valid %b busy %b, required 1 1", dut_if.byte_valid, busy);
        end
      end
    end
    total++;
    if (busy_cnt != 3) begin bad++; $display("FAIL press_busy_cycles: got %0d, required 3", busy_cnt); end
    @(posedge clk);
    #1;
    push_msg(1'b0, 8'h3C);
    note = 10'h000;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL press_drain: got timeout, required idle"); end
  endtask

  task automatic test_chord_stall();
    bit ok;
    dut_if.byte_ready = 1'b0;
    push_msg(1'b1, 8'h3C);
    push_msg(1'b1, 8'h40);
    note = 10'h005;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      total++;
      if (dut_if.byte_valid !== 1'b1 || dut_if.byte_data !== 8'h90) begin
        bad++; $display("FAIL stall_hold: got valid %b data 0x%02h, required 1 0x90", dut_if.byte_valid, dut_if.byte_data);
      end
    end
    @(posedge clk);
    #1 dut_if.byte_ready = 1'b1;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL chord_drain: got timeout, required idle"); end
    push_msg(1'b0, 8'h3C);
    push_msg(1'b0, 8'h40);
    note = 10'h000;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL chord_off_drain: got timeout, required idle"); end
  endtask

  task automatic test_back_to_back();
    int highs, falls;
    logic prev;
    bit ok;
    pitchshift = 5'd5;
    for (int i = 0; i < 10; i++) push_msg(1'b1, exp_key(60, i, 5));
    note = 10'h3FF;
    highs = 0; falls = 0; prev = 1'b0;
    repeat (44) begin
      @(negedge clk);
      if (dut_if.byte_valid) highs++;
      if (prev && !dut_if.byte_valid) falls++;
      prev = dut_if.byte_valid;
    end
    total++;
    if (highs != 30 || falls != 10) begin
      bad++; $display("FAIL b2b_cadence: got highs %0d falls %0d, required 30 10", highs, falls);
    end
    drain(ok);
    pitchshift = 5'b11001;
    for (int i = 0; i < 10; i++) push_msg(1'b0, exp_key(60, i, 5));
    note = 10'h000;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_drain: got timeout, required idle"); end
    pitchshift = 5'd0;
  endtask

  task automatic test_shift_latch();
    bit ok;
    pitchshift = 5'd3;
    push_msg(1'b1, 8'h41);
    note = 10'h002;
    drain(ok);
    pitchshift = 5'b11110;
    repeat (4) @(posedge clk);
    #1;
    push_msg(1'b0, 8'h41);
    note = 10'h000;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL latch_drain: got timeout, required idle"); end
    pitchshift = 5'd0;
  endtask

  task automatic test_clamp();
    logic [7:0] got_hi [3];
    logic [7:0] got_lo [3];
    int n_hi, n_lo;
    n_hi = 0; n_lo = 0;
    note_hi = 10'h200; shift_hi = 5'd15;
    note_lo = 10'h001; shift_lo = 5'b10000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (hi_if.byte_valid && n_hi < 3) begin got_hi[n_hi] = hi_if.byte_data; n_hi++; end
      if (lo_if.byte_valid && n_lo < 3) begin got_lo[n_lo] = lo_if.byte_data; n_lo++; end
    end
    total++;
    if (n_hi != 3 || n_lo != 3) begin
      bad++; $display("FAIL clamp_count: got %0d %0d, required 3 3", n_hi, n_lo);
    end else begin
      total++;
      if (got_hi[1] !== 8'h7F) begin bad++; $display("FAIL clamp_high: got 0x%02h, required 0x7F", got_hi[1]); end
      total++;
      if (got_lo[1] !== 8'h00) begin bad++; $display("FAIL clamp_low: got 0x%02h, required 0x00", got_lo[1]); end
      total++;
      if (got_hi[0] !== 8'h90 || got_lo[2] !== 8'h64) begin
        bad++; $display("FAIL clamp_frame: got 0x%02h 0x%02h, required 0x90 0x64", got_hi[0], got_lo[2]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_enable_drop();
    bit ok;
    push_msg(1'b1, 8'h41);
    push_msg(1'b1, 8'h48);
    note = 10'h088;
    drain(ok);
    push_msg(1'b0, 8'h41);
    push_msg(1'b0, 8'h48);
    ena = 1'b0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ena_off_drain: got timeout, required idle"); end
    push_msg(1'b1, 8'h41);
    push_msg(1'b1, 8'h48);
    ena = 1'b1;
    drain(ok);
    push_msg(1'b0, 8'h41);
    push_msg(1'b0, 8'h48);
    note = 10'h000;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ena_on_drain: got timeout, required idle"); end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    dut_if.byte_ready = 1'b0;
    sb.push_back(8'h90);
    note = 10'h001;
    @(posedge clk);
    @(posedge clk);
    #1 dut_if.byte_ready = 1'b1;
    @(posedge clk);
    #1 dut_if.byte_ready = 1'b0;
    @(negedge clk);
    total++;
    if (dut_if.byte_valid !== 1'b1 || dut_if.byte_data !== 8'h3C) begin
      bad++; $display("FAIL mid_key_pending: got valid %b data 0x%02h, required 1 0x3C", dut_if.byte_valid, dut_if.byte_data);
    end
    @(posedge clk);
    #1 rst = 1'b1; note = 10'h000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (dut_if.byte_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got valid %b busy %b, required 0 0", dut_if.byte_valid, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0; dut_if.byte_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (dut_if.byte_valid) vcnt++;
    end
    total++;
    if (vcnt != 0) begin bad++; $display("FAIL mid_no_bytes: got %0d valid cycles, required 0", vcnt); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_chord_stall();
    test_back_to_back();
    test_shift_latch();
    test_clamp();
    test_enable_drop();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL leftover_bytes: got %0d queued, required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
